// File: rtl/game_ctrl.sv
// game_ctrl
// ---------------------------------------------------------------------------
// Top-level sequencer for the slime game. Runs the play / pause / dying /
// game-over state machine, keeps the live two-digit BCD score, and emits a
// one-cycle slime_die strobe on the cycle the slime enters DYING. All
// outputs are registered. There is one cycle of latency from an input
// sampled on an edge to the outputs that follow that edge.
//
// Parameters
//   DIE_CYCLES  cycles spent in DYING (>= 2)
//   OVER_HOLD   minimum cycles in GAME_OVER before start is accepted (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   start/restart pulse
//   pause      in   pause toggle pulse
//   pass_tick  in   obstacle-cleared pulse (score +1)
//   collision  in   slime/obstacle overlap level
//   state      out  3-bit state code (see table below)
//   run        out  high only while PLAYING
//   score_0    out  ones digit of the score (BCD)
//   score_1    out  tens digit; 10 means the score has overflowed (>= 100)
//   slime_die  out  one-cycle death strobe
//
// state        | code | meaning
// -------------+------+--------------------------------------------------
// ST_IDLE      |  0   | after reset, waiting for start
// ST_PLAYING   |  1   | game running, score counts pass_tick
// ST_PAUSED    |  2   | frozen until the next pause pulse
// ST_DYING     |  3   | death animation, DIE_CYCLES long
// ST_GAME_OVER |  4   | score frozen, start accepted after OVER_HOLD
// ---------------------------------------------------------------------------

module game_ctrl #(
    parameter int DIE_CYCLES = 25_000_000,
    parameter int OVER_HOLD  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       pass_tick,
    input  logic       collision,
    output logic [2:0] state,
    output logic       run,
    output logic [3:0] score_0,
    output logic [3:0] score_1,
    output logic       slime_die
);

    // The die counter only ever holds 0..DIE_CYCLES-1.
    // The hold counter saturates at OVER_HOLD.
    localparam int DW = $clog2(DIE_CYCLES);
    localparam int HW = $clog2(OVER_HOLD + 1);

    localparam logic [DW-1:0] DIE_LAST  = DW'(DIE_CYCLES - 1);
    localparam logic [DW-1:0] DIE_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(OVER_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    localparam logic [3:0] TENS_OVF = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_DYING     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t        state_q, state_n;
    logic [DW-1:0] die_cnt_q, die_cnt_n;
    logic [HW-1:0] hold_cnt_q, hold_cnt_n;
    logic [3:0]    ones_q, ones_n;
    logic [3:0]    tens_q, tens_n;
    logic          run_q, run_n;
    logic          die_q, die_n;

    logic [3:0]    inc_ones;
    logic [3:0]    inc_tens;
    logic          hold_done;

    // Saturating BCD increment. Once the tens digit reaches the overflow
    // code, the score is frozen at 10/0.
    always_comb begin
        inc_ones = ones_q;
        inc_tens = tens_q;
        if (tens_q != TENS_OVF) begin
            if (ones_q == 4'd9) begin
                inc_ones = 4'd0;
                inc_tens = tens_q + 4'd1;
            end else begin
                inc_ones = ones_q + 4'd1;
            end
        end
    end

    // hold_cnt_q counts the edges already spent in GAME_OVER. A start that
    // is sampled on the edge completing OVER_HOLD cycles is accepted. This
    // means the current value only needs to reach OVER_HOLD-1.
    assign hold_done = (hold_cnt_q >= HOLD_LAST);

    always_comb begin
        state_n    = state_q;
        die_cnt_n  = die_cnt_q;
        hold_cnt_n = hold_cnt_q;
        ones_n     = ones_q;
        tens_n     = tens_q;
        die_n      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_PLAYING;
                    ones_n  = 4'd0;
                    tens_n  = 4'd0;
                end
            end

            ST_PLAYING: begin
                // A pass_tick in the collision cycle is not counted.
                if (collision) begin
                    state_n   = ST_DYING;
                    die_cnt_n = '0;
                    die_n     = 1'b1;
                end else if (pause) begin
                    state_n = ST_PAUSED;
                end else if (pass_tick) begin
                    ones_n = inc_ones;
                    tens_n = inc_tens;
                end
            end

            ST_PAUSED: begin
                if (pause) begin
                    state_n = ST_PLAYING;
                end
            end

            ST_DYING: begin
                if (die_cnt_q == DIE_LAST) begin
                    state_n    = ST_GAME_OVER;
                    hold_cnt_n = '0;
                end else begin
                    die_cnt_n = die_cnt_q + DIE_ONE;
                end
            end

            ST_GAME_OVER: begin
                // An early start is dropped; it is not remembered.
                if (start && hold_done) begin
                    state_n = ST_PLAYING;
                    ones_n  = 4'd0;
                    tens_n  = 4'd0;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_n = hold_cnt_q + HOLD_ONE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        run_n = (state_n == ST_PLAYING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            die_cnt_q  <= '0;
            hold_cnt_q <= '0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            run_q      <= 1'b0;
            die_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            die_cnt_q  <= die_cnt_n;
            hold_cnt_q <= hold_cnt_n;
            ones_q     <= ones_n;
            tens_q     <= tens_n;
            run_q      <= run_n;
            die_q      <= die_n;
        end
    end

    assign state     = state_q;
    assign run       = run_q;
    assign score_0   = ones_q;
    assign score_1   = tens_q;
    assign slime_die = die_q;

endmodule
